// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache and its main-memory miss controller:
// line geometry, miss-controller state encoding and the line-align helper.
package cache_pkg;

    localparam int LINE_BITS = 256;
    localparam int OFS_BITS  = 5;

    // Line-align mask for the default geometry (clears the OFS_BITS byte offset).
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } mmc_state_e;

    // Clear the byte-offset bits of an address; equals addr & LINE_MASK for
    // the default OFS_BITS.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int ofs_bits);
        logic [31:0] mask;
        mask = ~((32'd1 << ofs_bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/mm_ctrl_if.sv
// Miss-controller bus: request/fill side towards the cache FSM and command
// side towards main memory. The controller uses the slave modport; the
// environment (cache FSM plus memory) uses the master modport.
interface mm_ctrl_if #(
    parameter int LINE_BITS = cache_pkg::LINE_BITS
);
    // Cache FSM side
    logic                 req;
    logic                 req_ready;
    logic [31:0]          req_a;
    logic                 req_dirty;
    logic [31:0]          req_evict_a;
    logic [LINE_BITS-1:0] req_evict_wd;
    logic [LINE_BITS-1:0] fill_rd;
    logic                 fill_valid;
    logic                 err;
    // Main-memory side
    logic [31:0]          mm_a;
    logic [LINE_BITS-1:0] mm_wd;
    logic                 mm_write;
    logic                 mm_read;
    logic [LINE_BITS-1:0] mm_rd;
    logic                 mm_valid;

    modport slave (
        input  req, req_a, req_dirty, req_evict_a, req_evict_wd, mm_rd, mm_valid,
        output req_ready, fill_rd, fill_valid, err, mm_a, mm_wd, mm_write, mm_read
    );

    modport master (
        output req, req_a, req_dirty, req_evict_a, req_evict_wd, mm_rd, mm_valid,
        input  req_ready, fill_rd, fill_valid, err, mm_a, mm_wd, mm_write, mm_read
    );
endinterface

// File: rtl/mmc_timer.sv
// Watchdog counter for the miss controller. Counts cycles spent waiting in a
// memory-command state without a completion; o_tc flags the last allowed
// cycle (the LIMIT-th waiting cycle) when no completion arrives in it.
module mmc_timer #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_hit,
    output logic o_tc
);
    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // Cycle counter: cleared on entry to a command state, advanced while waiting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !i_hit) begin
            r_count <= r_count + CW'(1);
        end
    end

    // A completion in the limit cycle wins, so the hit masks the terminal count.
    assign o_tc = i_enable && !i_hit && (r_count == LAST);

endmodule

// File: rtl/mm_ctrl.sv
// Main-memory miss controller for the 4-way L1 cache. Sequences one line miss
// at a time: optional dirty-victim write-back (WB), then the line fill (FILL),
// then a one-cycle fill response (RESP).
// Optional watchdog: define MMC_TIMEOUT_EN to abort a command that receives no
// mm_valid within TIMEOUT_CYCLES cycles (err pulse, back to IDLE).
module mm_ctrl
    import cache_pkg::*;
#(
    parameter int LINE_BITS      = cache_pkg::LINE_BITS,
    parameter int OFS_BITS       = cache_pkg::OFS_BITS,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic     clk,
    input  logic     reset,
    mm_ctrl_if.slave bus
);
    mmc_state_e           r_state;
    logic [31:0]          r_req_a;
    logic [31:0]          r_mm_a;
    logic [LINE_BITS-1:0] r_mm_wd;
    logic [LINE_BITS-1:0] r_fill_rd;
    logic                 r_mm_write;
    logic                 r_mm_read;
    logic                 r_fill_valid;
    logic                 r_err;
    logic                 w_accept;
    logic                 w_timeout;

    assign w_accept = (r_state == ST_IDLE) && bus.req;

`ifdef MMC_TIMEOUT_EN
    logic w_timer_clear;
    logic w_timer_en;

    // Restart the count whenever a new command is about to be issued.
    assign w_timer_clear = w_accept || ((r_state == ST_WB) && bus.mm_valid);
    assign w_timer_en    = (r_state == ST_WB) || (r_state == ST_FILL);

    mmc_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .i_hit    (bus.mm_valid),
        .o_tc     (w_timeout)
    );
`else
    // Watchdog compiled out: never fires, so the controller waits for mm_valid
    // indefinitely. TIMEOUT_CYCLES stays referenced to keep one parameter list.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // Miss sequencer: state, memory commands and fill response, all registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the data registers are cleared too, so mm_a/mm_wd/fill_rd
            // read 0 after reset instead of holding stale line contents.
            r_state      <= ST_IDLE;
            r_req_a      <= '0;
            r_mm_a       <= '0;
            r_mm_wd      <= '0;
            r_fill_rd    <= '0;
            r_mm_write   <= 1'b0;
            r_mm_read    <= 1'b0;
            r_fill_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the
            // pre-edge state and the pulse defaults are simply overridden.
            r_fill_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_req_a <= bus.req_a;
                        if (bus.req_dirty) begin
                            r_mm_write <= 1'b1;
                            r_mm_a     <= line_align(bus.req_evict_a, OFS_BITS);
                            r_mm_wd    <= bus.req_evict_wd;
                            r_state    <= ST_WB;
                        end else begin
                            r_mm_read  <= 1'b1;
                            r_mm_a     <= line_align(bus.req_a, OFS_BITS);
                            r_state    <= ST_FILL;
                        end
                    end
                end
                ST_WB: begin
                    if (bus.mm_valid) begin
                        r_mm_write <= 1'b0;
                        r_mm_read  <= 1'b1;
                        r_mm_a     <= line_align(r_req_a, OFS_BITS);
                        r_state    <= ST_FILL;
                    end else if (w_timeout) begin
                        r_mm_write <= 1'b0;
                        r_err      <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (bus.mm_valid) begin
                        r_mm_read    <= 1'b0;
                        r_fill_rd    <= bus.mm_rd;
                        r_fill_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (w_timeout) begin
                        r_mm_read <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.mm_a       = r_mm_a;
    assign bus.mm_wd      = r_mm_wd;
    assign bus.mm_write   = r_mm_write;
    assign bus.mm_read    = r_mm_read;
    assign bus.fill_rd    = r_fill_rd;
    assign bus.fill_valid = r_fill_valid;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_mm_ctrl.sv
// Self-checking bench for mm_ctrl: directed misses are issued by a stimulus
// process that pushes the expected bus events (command starts, fill, err) with
// their cycle numbers; a monitor pops and compares each event as it appears.
module tb_mm_ctrl;

    localparam int LB = 256;

    localparam logic [LB-1:0] D_A5  = {32{8'hA5}};
    localparam logic [LB-1:0] D_WD1 = {4{64'h1234_5678_9ABC_DEF0}};
    localparam logic [LB-1:0] D_RD1 = {8{32'h0F0F_F0F0}};
    localparam logic [LB-1:0] D_WD2 = {8{32'hC3C3_3C3C}};
    localparam logic [LB-1:0] D_RD2 = {16{16'hBEEF}};
    localparam logic [LB-1:0] D_RD3 = {8{32'h5A5A_0001}};

    typedef enum int {EV_WR, EV_RD, EV_FILL, EV_ERR} ev_kind_e;

    typedef struct {
        ev_kind_e      kind;
        int            cyc;
        logic [31:0]   addr;
        logic [LB-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    // Memory model controls
    int            mem_lw = 0;
    int            mem_lr = 0;
    logic [LB-1:0] mem_data = '0;
    logic          resp_valid = 1'b0;
    logic          manual_valid = 1'b0;
    logic [LB-1:0] resp_rd = '0;

    always #5 clk = ~clk;

    mm_ctrl_if #(.LINE_BITS(LB)) bus ();

    mm_ctrl #(
        .LINE_BITS      (LB),
        .OFS_BITS       (5),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mm_valid = resp_valid | manual_valid;
    assign bus.mm_rd    = resp_rd;

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got no event within bound, expected event (cycle %0d)", name, cyc);
    endtask

    function automatic void expect_ev(input ev_kind_e k, input int c, input logic [31:0] a,
                                      input logic [LB-1:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic score(input ev_kind_e k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", int'(k), cyc);
            return;
        end
        e = exp_q.pop_front();
        check("ev_kind", int'(k), int'(e.kind));
        check("ev_cycle", cyc, e.cyc);
        case (k)
            EV_WR: begin
                check("wb_addr", bus.mm_a, e.addr);
                check("wb_data", bus.mm_wd, e.data);
            end
            EV_RD:   check("fill_addr", bus.mm_a, e.addr);
            EV_FILL: check("fill_data", bus.fill_rd, e.data);
            default: ;
        endcase
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    initial begin : monitor
        logic p_rd;
        logic p_wr;
        p_rd = 1'b0;
        p_wr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mm_read === 1'b1 || bus.mm_write === 1'b1)
                check("cmd_exclusive", bus.mm_read & bus.mm_write, 1'b0);
            // mm_valid still shows the value sampled at this edge.
            if (p_rd && bus.mm_valid === 1'b1) check("rd_drop", bus.mm_read, 1'b0);
            if (p_wr && bus.mm_valid === 1'b1) check("wr_drop", bus.mm_write, 1'b0);
            if (bus.mm_write === 1'b1 && !p_wr) score(EV_WR);
            if (bus.mm_read === 1'b1 && !p_rd)  score(EV_RD);
            if (bus.fill_valid === 1'b1)        score(EV_FILL);
            if (bus.err === 1'b1)               score(EV_ERR);
            p_rd = (bus.mm_read === 1'b1);
            p_wr = (bus.mm_write === 1'b1);
        end
    end

    // Memory model: completes a command mem_lw/mem_lr cycles after it rises;
    // read data is garbage outside the completion cycle.
    initial begin : responder
        int age;
        int last;
        age  = 0;
        last = 0;
        forever begin
            @(negedge clk);
            if (bus.mm_write === 1'b1) begin
                age        = (last == 1) ? age + 1 : 0;
                last       = 1;
                resp_valid = (age == mem_lw);
                resp_rd    = '0;
            end else if (bus.mm_read === 1'b1) begin
                age        = (last == 2) ? age + 1 : 0;
                last       = 2;
                resp_valid = (age == mem_lr);
                resp_rd    = resp_valid ? mem_data : ~mem_data;
            end else begin
                last       = 0;
                resp_valid = 1'b0;
                resp_rd    = '0;
            end
        end
    end

    // Wait (at a falling edge) for req_ready, then present a request; t is the
    // cycle whose closing edge accepts it.
    task automatic issue(input logic [31:0] a, input logic dirty, input logic [31:0] ea,
                         input logic [LB-1:0] ewd, input int lw, input int lr,
                         input logic [LB-1:0] rdata, output int t);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) fail_bound("req_ready_wait");
        mem_lw           = lw;
        mem_lr           = lr;
        mem_data         = rdata;
        bus.req_a        = a;
        bus.req_dirty    = dirty;
        bus.req_evict_a  = ea;
        bus.req_evict_wd = ewd;
        bus.req          = 1'b1;
        t                = cyc;
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_bound("drain");
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check({tag, "_mm_read"},   bus.mm_read, 1'b0);
        check({tag, "_mm_write"},  bus.mm_write, 1'b0);
        check({tag, "_fill_valid"}, bus.fill_valid, 1'b0);
        check({tag, "_err"},       bus.err, 1'b0);
    endtask

    initial begin : stim
        int t;
        bus.req          = 1'b0;
        bus.req_a        = '0;
        bus.req_dirty    = 1'b0;
        bus.req_evict_a  = '0;
        bus.req_evict_wd = '0;
        reset            = 1'b0;

        // Reset for two cycles, then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("rst");
        check("rst_mm_a",    bus.mm_a, 32'h0);
        check("rst_mm_wd",   bus.mm_wd, '0);
        check("rst_fill_rd", bus.fill_rd, '0);

        // Clean miss, L=3.
        issue(32'h0001_2347, 1'b0, 32'h0, '0, 0, 3, D_A5, t);
        expect_ev(EV_RD,   t + 1, 32'h0001_2340, '0);
        expect_ev(EV_FILL, t + 5, 32'h0, D_A5);
        release_req();
        wait_drain(40);
        check("resp_not_ready", bus.req_ready, 1'b0);
        @(negedge clk);
        check("ready_after_resp", bus.req_ready, 1'b1);

        // Stray mm_valid in IDLE.
        manual_valid = 1'b1;
        @(negedge clk);
        manual_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("stray_valid");
        check("fill_rd_hold", bus.fill_rd, D_A5);

        // Dirty miss, Lw=0, Lr=0.
        issue(32'h0000_ABCD, 1'b1, 32'h00FF_001F, D_WD1, 0, 0, D_RD1, t);
        expect_ev(EV_WR,   t + 1, 32'h00FF_0000, D_WD1);
        expect_ev(EV_RD,   t + 2, 32'h0000_ABC0, '0);
        expect_ev(EV_FILL, t + 3, 32'h0, D_RD1);
        release_req();
        wait_drain(40);

        // Dirty miss, Lw=2, Lr=1, top-of-space victim.
        issue(32'h8000_0021, 1'b1, 32'hFFFF_FFFF, D_WD2, 2, 1, D_RD2, t);
        expect_ev(EV_WR,   t + 1, 32'hFFFF_FFE0, D_WD2);
        expect_ev(EV_RD,   t + 4, 32'h8000_0020, '0);
        expect_ev(EV_FILL, t + 6, 32'h0, D_RD2);
        release_req();
        wait_drain(40);

        // Clean miss with a stray dirty req pulsed during FILL.
        issue(32'h0000_1000, 1'b0, 32'h0, '0, 0, 5, D_RD1, t);
        expect_ev(EV_RD,   t + 1, 32'h0000_1000, '0);
        expect_ev(EV_FILL, t + 7, 32'h0, D_RD1);
        release_req();
        @(negedge clk);
        bus.req          = 1'b1;
        bus.req_a        = 32'hDEAD_BEEF;
        bus.req_dirty    = 1'b1;
        bus.req_evict_a  = 32'h1111_1111;
        bus.req_evict_wd = ~D_WD2;
        @(negedge clk);
        bus.req          = 1'b0;
        bus.req_dirty    = 1'b0;
        wait_drain(40);
        check("mm_wd_hold", bus.mm_wd, D_WD2);

        // Reset mid-FILL, then a late memory response.
        issue(32'h0000_2040, 1'b0, 32'h0, '0, 0, -1, D_RD3, t);
        expect_ev(EV_RD, t + 1, 32'h0000_2040, '0);
        release_req();
        @(negedge clk);
        check("rd_before_reset", bus.mm_read, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset        = 1'b1;
        manual_valid = 1'b1;
        @(negedge clk);
        manual_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("mid_rst");
        check("mid_rst_mm_a",    bus.mm_a, 32'h0);
        check("mid_rst_mm_wd",   bus.mm_wd, '0);
        check("mid_rst_fill_rd", bus.fill_rd, '0);
        wait_drain(5);

`ifdef MMC_TIMEOUT_EN
        // Memory never answers: err after 8 FILL cycles.
        issue(32'h0000_3000, 1'b0, 32'h0, '0, 0, -1, D_RD3, t);
        expect_ev(EV_RD,  t + 1, 32'h0000_3000, '0);
        expect_ev(EV_ERR, t + 9, 32'h0, '0);
        release_req();
        wait_drain(40);
        check("to_mm_read",   bus.mm_read, 1'b0);
        check("to_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        check("to_err_pulse", bus.err, 1'b0);

        // mm_valid in the 8th FILL cycle completes normally.
        issue(32'h0000_3004, 1'b0, 32'h0, '0, 0, 7, D_RD3, t);
        expect_ev(EV_RD,   t + 1, 32'h0000_3000, '0);
        expect_ev(EV_FILL, t + 9, 32'h0, D_RD3);
        release_req();
        wait_drain(40);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : guard
        #300000;
        $display("FAIL global_timeout: got still running, expected finished (cycle %0d)", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
